multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Parametrised multicycle MIPS-subset controller: Moore FSM sequencing fetch/decode/execute/mem/writeback over several cycles.
//  Embeds ALU function decode. Adds memory-ready stall handshake and illegal-opcode flagging.
//  Sits between the instruction register (op/funct) and the shared-memory multicycle datapath.
// PARAMETERS
//  OP_W      6  opcode width
//  FUNCT_W   6  funct width
//  ALUCTL_W  3  ALUControl width (>=3; upper bits zero-filled)
//  WAIT_EN   1  1: memory states hold until mem_ready=1; 0: mem_ready ignored, single-cycle memory
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous, active-low reset
//  op          in   OP_W      opcode from instruction register
//  funct       in   FUNCT_W   funct field from instruction register
//  zero        in   1         ALU zero flag (beq)
//  mem_ready   in   1         memory access completes this cycle
//  PCWrite     out  1         PC load enable (branch-qualified load folded in)
//  IorD        out  1         memory address mux: 0 PC, 1 ALUOut
//  MemWrite    out  1         data memory write strobe
//  IRWrite     out  1         instruction register load
//  RegDst      out  1         dest reg: 0 rt, 1 rd
//  MemtoReg    out  1         writeback: 0 ALUOut, 1 MDR
//  RegWrite    out  1         register file write enable
//  ALUSrcA     out  1         0 PC, 1 rs
//  ALUSrcB     out  2         00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  PCSrc       out  2         00 ALU result, 01 ALUOut, 10 jump target
//  HalfWord    out  1         memory access is 16-bit (lh/sh)
//  Shift       out  1         ALU A operand is shamt (sll/srl)
//  ALUControl  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll, 100 srl
//  illegal_op  out  1         one-cycle pulse in DECODE on unsupported op/funct
//  state_o     out  4         current state encoding (debug)
// BEHAVIOUR
//  - Reset: state<=FETCH asynchronously. While rst_n=0, PCWrite/MemWrite/IRWrite/RegWrite/illegal_op forced 0;
//    other outputs take FETCH decode. First fetch is on first clk edge after release.
//  - Outputs are Moore decode of state. ALUControl/Shift in EXECUTE also depend on funct.
//  - Opcodes: R 000000, lw 100011, sw 101011, lh 100001, sh 101001, beq 000100, addi 001000, j 000010.
//  - States/transitions:
//    FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
//      IRWrite=PCWrite=mem_ready (1 if WAIT_EN=0). Stays in FETCH until ready, then -> DECODE.
//    DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target).
//      Next: lw/lh/sw/sh->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP.
//      Unsupported op, or R with funct outside the ALU table, -> FETCH with illegal_op=1 for this cycle.
//    MEMADR: ALUSrcA=1, ALUSrcB=10, add. -> MEMRD (lw/lh) or MEMWR (sw/sh).
//    MEMRD: IorD=1, holds until mem_ready. -> MEMWB.
//    MEMWR: IorD=1, MemWrite=1 every cycle held. -> FETCH on mem_ready.
//    MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH.
//    HalfWord=1 through MEMADR..MEMWB for lh/sh, else 0.
//    EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl per funct:
//      100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl.
//      Shift=1 only for sll/srl. -> ALUWB.
//    ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. -> FETCH.
//    BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=zero. -> FETCH.
//    ADDIEX: ALUSrcA=1, ALUSrcB=10, add. -> ADDIWB.
//    ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH.
//    JUMP: PCSrc=10, PCWrite=1. -> FETCH.
//  - Outputs not listed for a state are 0 / don't-care-driven-0. Enables are never X.
//  - Stall: mem_ready sampled only in FETCH/MEMRD/MEMWR. Elsewhere it is ignored.
//  - Reset mid-access: FETCH entered immediately and enables drop the same instant. No partial write completes after reset.
//  - op/funct are assumed stable from DECODE to end of instruction (IR loads only in FETCH).
//  - Latency with no stalls: lw/lh 5, sw/sh 4, R 4, addi 4, beq 3, j 3 cycles.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode/funct localparams, ALUControl codes, state encoding.
//  - One sub-module: alu_func_decoder (funct -> ALUControl, Shift, legal). Reused for DECODE legality and EXECUTE.
//  - FSM: single state register, next-state always block, output decode always block.
// TESTING
//  1 Reset held 3 cycles during MEMWR with mem_ready=1 -> MemWrite=0 immediately, state_o=FETCH, IRWrite=0 until release.
//  2 lw, WAIT_EN=1, mem_ready low 2 cycles in FETCH and MEMRD -> IRWrite single pulse on ready, RegWrite+MemtoReg in MEMWB, 9 cycles total.
//  3 R sub (funct 100010) -> EXECUTE ALUControl=110 Shift=0. ALUWB RegDst=1 RegWrite=1. R sll (000000) -> ALUControl=011 Shift=1.
//  4 beq with zero=1 then zero=0 -> PCWrite=1 PCSrc=01 in BRANCH; then PCWrite=0. Both return to FETCH.
//  5 op=111111 and R funct=001000 -> illegal_op pulse in DECODE, next state FETCH, no RegWrite/MemWrite.
//  6 sh then j, WAIT_EN=0 -> HalfWord=1 for MEMADR/MEMWR, MemWrite 1 cycle. JUMP PCSrc=10 PCWrite=1, 4+3 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: opcodes, funct
// codes, ALU operation encoding, datapath mux selects and FSM state encoding.
package mips_ctrl_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes understood by the ALU
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

endpackage

// File: rtl/alu_func_decoder.sv
// R-type funct decoder: ALU operation, shamt-operand select and legality.
// Shared by DECODE (legality) and EXECUTE (operation select).
module alu_func_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  output alu_ctl_e           alu_ctl,
  output logic               shift,
  output logic               legal
);

  // Map funct onto an ALU operation; anything outside the table is illegal.
  always_comb begin
    // NOTE: every output is given a default before the case so no path leaves it unassigned and no latch is inferred.
    alu_ctl = ALU_ADD;
    shift   = 1'b0;
    legal   = 1'b1;
    case (funct)
      FUNCT_W'(FN_ADD): alu_ctl = ALU_ADD;
      FUNCT_W'(FN_SUB): alu_ctl = ALU_SUB;
      FUNCT_W'(FN_AND): alu_ctl = ALU_AND;
      FUNCT_W'(FN_OR):  alu_ctl = ALU_OR;
      FUNCT_W'(FN_SLT): alu_ctl = ALU_SLT;
      FUNCT_W'(FN_SLL): begin alu_ctl = ALU_SLL; shift = 1'b1; end
      FUNCT_W'(FN_SRL): begin alu_ctl = ALU_SRL; shift = 1'b1; end
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset controller. Moore FSM walking each instruction through
// fetch/decode/execute/memory/writeback, with a memory-ready stall handshake and
// an illegal-instruction pulse in DECODE.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3,
  parameter int WAIT_EN  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic                HalfWord,
  output logic                Shift,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                illegal_op,
  output logic [3:0]          state_o
);

  state_e   state, state_next;
  logic     ready;
  logic     is_r, is_lw, is_sw, is_lh, is_sh, is_beq, is_addi, is_j;
  logic     is_mem, is_store, is_half;
  alu_ctl_e fn_alu;
  logic     fn_shift, fn_legal;
  alu_ctl_e alu_sel;
  logic     pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

  // Without the wait handshake every memory access completes in one cycle.
  assign ready = (WAIT_EN != 0) ? mem_ready : 1'b1;

  assign is_r     = (op == OP_W'(OP_RTYPE));
  assign is_lw    = (op == OP_W'(OP_LW));
  assign is_sw    = (op == OP_W'(OP_SW));
  assign is_lh    = (op == OP_W'(OP_LH));
  assign is_sh    = (op == OP_W'(OP_SH));
  assign is_beq   = (op == OP_W'(OP_BEQ));
  assign is_addi  = (op == OP_W'(OP_ADDI));
  assign is_j     = (op == OP_W'(OP_J));
  assign is_mem   = is_lw | is_sw | is_lh | is_sh;
  assign is_store = is_sw | is_sh;
  assign is_half  = is_lh | is_sh;

  alu_func_decoder #(.FUNCT_W(FUNCT_W)) u_alu_func_decoder (
    .funct   (funct),
    .alu_ctl (fn_alu),
    .shift   (fn_shift),
    .legal   (fn_legal)
  );

  // State register; reset drops straight back to FETCH, even mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state selection; mem_ready only matters in the memory-access states.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (ready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_mem)                 state_next = S_MEMADR;
        else if (is_r && fn_legal)  state_next = S_EXECUTE;
        else if (is_beq)            state_next = S_BRANCH;
        else if (is_addi)           state_next = S_ADDIEX;
        else if (is_j)              state_next = S_JUMP;
        else                        state_next = S_FETCH;
      end
      S_MEMADR:  state_next = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ready) state_next = S_MEMWB;
      S_MEMWR:   if (ready) state_next = S_FETCH;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Moore output decode; only the write enables look at mem_ready/zero.
  always_comb begin
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_RT;
    PCSrc        = PCSRC_ALU;
    HalfWord     = 1'b0;
    Shift        = 1'b0;
    alu_sel      = ALU_AND;
    pcwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB     = SRCB_FOUR;
        alu_sel     = ALU_ADD;
        PCSrc       = PCSRC_ALU;
        pcwrite_raw = ready;
        irwrite_raw = ready;
      end
      S_DECODE: begin
        ALUSrcB     = SRCB_IMM_SH2;
        alu_sel     = ALU_ADD;
        illegal_raw = ~(is_mem | (is_r & fn_legal) | is_beq | is_addi | is_j);
      end
      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_sel  = ALU_ADD;
        HalfWord = is_half;
      end
      S_MEMRD: begin
        IorD     = 1'b1;
        HalfWord = is_half;
      end
      S_MEMWR: begin
        IorD         = 1'b1;
        memwrite_raw = 1'b1;
        HalfWord     = is_half;
      end
      S_MEMWB: begin
        MemtoReg     = 1'b1;
        regwrite_raw = 1'b1;
        HalfWord     = is_half;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_sel = fn_alu;
        Shift   = fn_shift;
      end
      S_ALUWB: begin
        RegDst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        alu_sel     = ALU_SUB;
        PCSrc       = PCSRC_ALUOUT;
        pcwrite_raw = zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_sel = ALU_ADD;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        PCSrc       = PCSRC_JUMP;
        pcwrite_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset directly so they drop the instant rst_n falls.
  assign PCWrite    = rst_n & pcwrite_raw;
  assign MemWrite   = rst_n & memwrite_raw;
  assign IRWrite    = rst_n & irwrite_raw;
  assign RegWrite   = rst_n & regwrite_raw;
  assign illegal_op = rst_n & illegal_raw;

  assign ALUControl = ALUCTL_W'(alu_sel);
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one instance with the memory
// wait handshake, one without. Expected outputs are written out per state.
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regdst;
    logic       memtoreg;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       hw;
    logic       shift;
    logic [2:0] alu;
    logic       ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Instance A: WAIT_EN=1
  logic [3:0] a_st;
  logic       a_pcw, a_iord, a_memw, a_irw, a_regdst, a_memtoreg, a_regw, a_srca;
  logic [1:0] a_srcb, a_pcsrc;
  logic       a_hw, a_shift, a_ill;
  logic [2:0] a_alu;
  obs_t       obs_a;

  // Instance B: WAIT_EN=0
  logic [3:0] b_st;
  logic       b_pcw, b_iord, b_memw, b_irw, b_regdst, b_memtoreg, b_regw, b_srca;
  logic [1:0] b_srcb, b_pcsrc;
  logic       b_hw, b_shift, b_ill;
  logic [2:0] b_alu;
  obs_t       obs_b;

  multicycle_control_unit #(.WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .IorD(a_iord), .MemWrite(a_memw), .IRWrite(a_irw), .RegDst(a_regdst),
    .MemtoReg(a_memtoreg), .RegWrite(a_regw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb),
    .PCSrc(a_pcsrc), .HalfWord(a_hw), .Shift(a_shift), .ALUControl(a_alu),
    .illegal_op(a_ill), .state_o(a_st)
  );

  multicycle_control_unit #(.WAIT_EN(0)) dut_nowait (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .IorD(b_iord), .MemWrite(b_memw), .IRWrite(b_irw), .RegDst(b_regdst),
    .MemtoReg(b_memtoreg), .RegWrite(b_regw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb),
    .PCSrc(b_pcsrc), .HalfWord(b_hw), .Shift(b_shift), .ALUControl(b_alu),
    .illegal_op(b_ill), .state_o(b_st)
  );

  assign obs_a = {a_st, a_pcw, a_iord, a_memw, a_irw, a_regdst, a_memtoreg, a_regw, a_srca,
                  a_srcb, a_pcsrc, a_hw, a_shift, a_alu, a_ill};
  assign obs_b = {b_st, b_pcw, b_iord, b_memw, b_irw, b_regdst, b_memtoreg, b_regw, b_srca,
                  b_srcb, b_pcsrc, b_hw, b_shift, b_alu, b_ill};

  // Hand-written expected outputs per state. dyn = FETCH PCWrite/IRWrite or BRANCH PCWrite.
  function automatic obs_t ex(input state_e s, input logic dyn, input logic hw,
                              input logic [2:0] xalu, input logic xsh, input logic ill);
    obs_t e = '0;
    e.st = s;
    case (s)
      S_FETCH:   begin e.srcb = 2'b01; e.alu = 3'b010; e.pcw = dyn; e.irw = dyn; end
      S_DECODE:  begin e.srcb = 2'b11; e.alu = 3'b010; e.ill = ill; end
      S_MEMADR:  begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = 3'b010; e.hw = hw; end
      S_MEMRD:   begin e.iord = 1'b1; e.hw = hw; end
      S_MEMWR:   begin e.iord = 1'b1; e.memw = 1'b1; e.hw = hw; end
      S_MEMWB:   begin e.memtoreg = 1'b1; e.regw = 1'b1; e.hw = hw; end
      S_EXECUTE: begin e.srca = 1'b1; e.alu = xalu; e.shift = xsh; end
      S_ALUWB:   begin e.regdst = 1'b1; e.regw = 1'b1; end
      S_BRANCH:  begin e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcw = dyn; end
      S_ADDIEX:  begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = 3'b010; end
      S_ADDIWB:  e.regw = 1'b1;
      S_JUMP:    begin e.pcsrc = 2'b10; e.pcw = 1'b1; end
      default:   ;
    endcase
    return e;
  endfunction

  function automatic obs_t e0(input state_e s);
    return ex(s, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h (state %0d) expected %h (state %0d)",
               tag, obs, obs.st, exp, exp.st);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check instance A for the current cycle, then advance one clock.
  task automatic step_a(input string tag, input obs_t e);
    #1;
    check(tag, obs_a, e);
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input string tag, input obs_t e);
    #1;
    check(tag, obs_b, e);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
  logic [2:0] alu_tab [7] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b011,    3'b100};
  logic       sh_tab  [7] = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1,      1'b1};

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; op = OP_RTYPE; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_a_async", obs_a, e0(S_FETCH));
    check("rst_b_async", obs_b, e0(S_FETCH));
    step_a("rst_a_hold", e0(S_FETCH));
    rst_n = 1'b1; mem_ready = 1'b0;
    step_a("rst_release", e0(S_FETCH));

    // 1: reset asserted during a held MEMWR with mem_ready=1
    op = OP_SW;
    step_a("t1_fetch_stall", e0(S_FETCH));
    mem_ready = 1'b1;
    step_a("t1_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    step_a("t1_decode", e0(S_DECODE));
    step_a("t1_memadr", e0(S_MEMADR));
    step_a("t1_memwr_hold", e0(S_MEMWR));
    rst_n = 1'b0; mem_ready = 1'b1;
    step_a("t1_rst_c1", e0(S_FETCH));
    step_a("t1_rst_c2", e0(S_FETCH));
    step_a("t1_rst_c3", e0(S_FETCH));
    rst_n = 1'b1; mem_ready = 1'b0;
    step_a("t1_release", e0(S_FETCH));

    // 2: lw with two stall cycles in FETCH and in MEMRD: 9 cycles
    op = OP_LW;
    step_a("t2_c1_fetch", e0(S_FETCH));
    step_a("t2_c2_fetch", e0(S_FETCH));
    mem_ready = 1'b1;
    step_a("t2_c3_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    step_a("t2_c4_decode", e0(S_DECODE));
    step_a("t2_c5_memadr", e0(S_MEMADR));
    step_a("t2_c6_memrd", e0(S_MEMRD));
    step_a("t2_c7_memrd", e0(S_MEMRD));
    mem_ready = 1'b1;
    step_a("t2_c8_memrd", e0(S_MEMRD));
    mem_ready = 1'b0;
    step_a("t2_c9_memwb", e0(S_MEMWB));
    step_a("t2_done", e0(S_FETCH));

    // lh without stalls: HalfWord through MEMADR..MEMWB
    op = OP_LH; mem_ready = 1'b1;
    step_a("lh_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    step_a("lh_decode", e0(S_DECODE));
    step_a("lh_memadr", ex(S_MEMADR, 1'b0, 1'b1, 3'b0, 1'b0, 1'b0));
    step_a("lh_memrd", ex(S_MEMRD, 1'b0, 1'b1, 3'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    step_a("lh_memwb", ex(S_MEMWB, 1'b0, 1'b1, 3'b0, 1'b0, 1'b0));

    // 3: every R-type funct through EXECUTE/ALUWB
    op = OP_RTYPE;
    for (int i = 0; i < 7; i++) begin
      funct = fn_tab[i]; mem_ready = 1'b1;
      step_a($sformatf("t3_fetch_%0d", i), ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
      mem_ready = 1'b0;
      step_a($sformatf("t3_decode_%0d", i), e0(S_DECODE));
      step_a($sformatf("t3_exec_%0d", i), ex(S_EXECUTE, 1'b0, 1'b0, alu_tab[i], sh_tab[i], 1'b0));
      step_a($sformatf("t3_aluwb_%0d", i), e0(S_ALUWB));
    end

    // 4: beq taken then not taken
    op = OP_BEQ;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0]; mem_ready = 1'b1;
      step_a($sformatf("t4_fetch_z%0d", z), ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
      mem_ready = 1'b0;
      step_a($sformatf("t4_decode_z%0d", z), e0(S_DECODE));
      step_a($sformatf("t4_branch_z%0d", z), ex(S_BRANCH, z[0], 1'b0, 3'b0, 1'b0, 1'b0));
    end
    zero = 1'b0;
    step_a("t4_back", e0(S_FETCH));

    // addi
    op = OP_ADDI; mem_ready = 1'b1;
    step_a("addi_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    step_a("addi_decode", e0(S_DECODE));
    step_a("addi_ex", e0(S_ADDIEX));
    step_a("addi_wb", e0(S_ADDIWB));

    // 5: illegal opcode, then R-type with an unknown funct
    op = 6'b111111; mem_ready = 1'b1;
    step_a("t5_op_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    step_a("t5_op_decode", ex(S_DECODE, 1'b0, 1'b0, 3'b0, 1'b0, 1'b1));
    step_a("t5_op_back", e0(S_FETCH));
    op = OP_RTYPE; funct = 6'b001000; mem_ready = 1'b1;
    step_a("t5_fn_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    step_a("t5_fn_decode", ex(S_DECODE, 1'b0, 1'b0, 3'b0, 1'b0, 1'b1));
    step_a("t5_fn_back", e0(S_FETCH));

    // 6: sh then j on the instance without the wait handshake
    rst_n = 1'b0;
    step_b("t6_rst", e0(S_FETCH));
    rst_n = 1'b1; mem_ready = 1'b0; op = OP_SH;
    step_b("t6_sh_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    step_b("t6_sh_decode", e0(S_DECODE));
    step_b("t6_sh_memadr", ex(S_MEMADR, 1'b0, 1'b1, 3'b0, 1'b0, 1'b0));
    step_b("t6_sh_memwr", ex(S_MEMWR, 1'b0, 1'b1, 3'b0, 1'b0, 1'b0));
    op = OP_J;
    step_b("t6_j_fetch", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));
    step_b("t6_j_decode", e0(S_DECODE));
    step_b("t6_j_jump", e0(S_JUMP));
    step_b("t6_j_back", ex(S_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
